signed_divider: RTL and testbench

Sequential signed integer divider: the inverse of the calculator's Booth multiplier. Shares its start/done handshake and two's-complement operand format, so the keypad FSM can issue `A ÷ B` the same way it issues `A × B`. Restoring division on operand magnitudes, one quotient bit per clock, sign correction at the end. Quotient and remainder feed the existing binary→BCD and display path.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/signed_divider_if.sv | 39 +++
 rtl/div_restore_step.sv | 42 ++++
 rtl/signed_divider.sv | 171 +++++++++++++++++
 tb/tb_signed_divider.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types, divider widths and magnitude helper
//
// Contents:
//   div_state_t  divider sequencer states (IDLE, CALC, FIX, DONE)
//   DIV_N/DIV_M  default dividend/quotient and divisor/remainder widths
//   abs_mag      conditional two's-complement negation, 32 bits wide
package calc_pkg;

    localparam int DIV_N = 10;
    localparam int DIV_M = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Returns v negated when neg is set, else v unchanged. Used both to take
    // operand magnitudes (neg = operand sign) and to re-apply a result sign,
    // since two's-complement negation is its own inverse. Callers zero-extend
    // into 32 bits and size-cast the result back, so widths up to 32 work.
    function automatic logic [31:0] abs_mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/signed_divider_if.sv
// rtl/signed_divider_if.sv - start/done handshake and operand/result bundle for the divider
//
// Signals:
//   start      request, sampled by the divider in IDLE
//   dividend   N-bit signed dividend
//   divisor    M-bit signed divisor
//   quotient   N-bit signed quotient, truncated toward zero
//   remainder  M-bit signed remainder, sign of the dividend
//   busy       division in progress
//   done       one-cycle completion pulse
//   div_zero   divisor was zero
//   ovf        quotient not representable
// Modports: master (issuer, e.g. keypad FSM / bench), slave (divider).
interface signed_divider_if #(
    parameter int N = calc_pkg::DIV_N,
    parameter int M = calc_pkg::DIV_M
) ();

    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero, ovf
    );

endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one restoring-division bit: shift, trial-subtract, restore
//
// Ports:
//   prem_i   [M:0]   partial remainder before this bit
//   shreg_i  [N-1:0] dividend/quotient shift register before this bit
//   dmag_i   [M:0]   divisor magnitude, zero-extended
//   prem_o   [M:0]   partial remainder after this bit
//   shreg_o  [N-1:0] shift register after this bit (new quotient bit in LSB)
module div_restore_step #(
    parameter int N = 10,
    parameter int M = 5
) (
    input  logic [M:0]   prem_i,
    input  logic [N-1:0] shreg_i,
    input  logic [M:0]   dmag_i,
    output logic [M:0]   prem_o,
    output logic [N-1:0] shreg_o
);

    logic [M+1:0] shifted;
    logic         fits;
    logic [M:0]   diff;

    always_comb begin
        // {partial remainder, dividend} shifted left: next dividend bit enters
        // the remainder while the vacated LSB of the shift register will take
        // the quotient bit.
        shifted = {prem_i, shreg_i[N-1]};
        fits    = (shifted >= {1'b0, dmag_i});
        // When it fits, the difference is below the divisor magnitude, so the
        // low M+1 bits hold it exactly.
        diff    = shifted[M:0] - dmag_i;
        if (fits) begin
            prem_o  = diff;
            shreg_o = {shreg_i[N-2:0], 1'b1};
        end else begin
            prem_o  = shifted[M:0];
            shreg_o = {shreg_i[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/signed_divider.sv
// rtl/signed_divider.sv - sequential signed restoring divider, one quotient bit per clock
//
// Ports:
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   signed_divider_if.slave: start/dividend/divisor in,
//         quotient/remainder/busy/done/div_zero/ovf out
// Parameters: N dividend/quotient width, M divisor/remainder width (M <= N <= 32).
// Build option: DIV_OVF_SAT_EN - saturate an overflowing quotient to
//   +2^(N-1)-1 instead of wrapping to -2^(N-1); ovf is flagged either way.
module signed_divider
    import calc_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic             clk,
    input  logic             rst,
    signed_divider_if.slave  bus
);

    localparam int CW = $clog2(N + 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dd_neg_q, dd_neg_d;
    logic          dv_neg_q, dv_neg_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [M:0]    prem_q, prem_d;
    logic [M:0]    dmag_q, dmag_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [M-1:0]  rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic [M:0]    step_prem;
    logic [N-1:0]  step_shreg;

    logic          q_neg;
    logic          q_ovf;
    logic [N-1:0]  q_fixed;
    logic [M-1:0]  r_fixed;
    logic [N-1:0]  dd_mag;
    logic [M-1:0]  dv_mag;

    div_restore_step #(
        .N (N),
        .M (M)
    ) u_step (
        .prem_i  (prem_q),
        .shreg_i (shreg_q),
        .dmag_i  (dmag_q),
        .prem_o  (step_prem),
        .shreg_o (step_shreg)
    );

    // Operand magnitudes at acceptance. -2^(N-1) maps to the unsigned
    // pattern 100..0, which is exactly its magnitude.
    always_comb begin
        dd_mag = N'(abs_mag(32'(bus.dividend), bus.dividend[N-1]));
        dv_mag = M'(abs_mag(32'(bus.divisor), bus.divisor[M-1]));
    end

    // Sign correction of the finished magnitudes. The quotient magnitude can
    // only reach 2^(N-1) for -2^(N-1) / +-1; with a positive result sign that
    // value has no N-bit representation, which is the overflow case.
    always_comb begin
        q_neg   = dd_neg_q ^ dv_neg_q;
        q_ovf   = shreg_q[N-1] & ~q_neg;
        q_fixed = N'(abs_mag(32'(shreg_q), q_neg));
        r_fixed = M'(abs_mag(32'(prem_q[M-1:0]), dd_neg_q));
`ifdef DIV_OVF_SAT_EN
        if (q_ovf) begin
            q_fixed = {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dd_neg_d = dd_neg_q;
        dv_neg_d = dv_neg_q;
        shreg_d  = shreg_q;
        prem_d   = prem_q;
        dmag_d   = dmag_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d  = '0;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        dd_neg_d = bus.dividend[N-1];
                        dv_neg_d = bus.divisor[M-1];
                        shreg_d  = dd_mag;
                        dmag_d   = {1'b0, dv_mag};
                        prem_d   = '0;
                        cnt_d    = CW'(N);
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                prem_d  = step_prem;
                shreg_d = step_shreg;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = q_fixed;
                rem_d   = r_fixed;
                ovf_d   = q_ovf;
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dd_neg_q <= 1'b0;
            dv_neg_q <= 1'b0;
            shreg_q  <= '0;
            prem_q   <= '0;
            dmag_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dd_neg_q <= dd_neg_d;
            dv_neg_q <= dv_neg_d;
            shreg_q  <= shreg_d;
            prem_q   <= prem_d;
            dmag_q   <= dmag_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q == CALC) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_signed_divider.sv
// tb/tb_signed_divider.sv - table-driven directed bench for signed_divider (N=10, M=5)
module tb_signed_divider;

    localparam int N = 10;
    localparam int M = 5;
    localparam int LAT = N + 2;
`ifdef DIV_OVF_SAT_EN
    localparam int OVF_Q = 511;
`else
    localparam int OVF_Q = -512;
`endif

    typedef struct {
        int dd;
        int dv;
        int q;
        int r;
        int dz;
        int ov;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs[12];

    signed_divider_if #(.N(N), .M(M)) bus ();

    signed_divider #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int q_act();
        return $signed(bus.quotient);
    endfunction

    function automatic int r_act();
        return $signed(bus.remainder);
    endfunction

    // Called 1 time unit after an edge; start is sampled at the next edge.
    task automatic issue(input int dd, input int dv);
        bus.start    = 1'b1;
        bus.dividend = N'(dd);
        bus.divisor  = M'(dv);
        step();
        bus.start = 1'b0;
    endtask

    // Counts cycles after the sampling edge until done, checking busy.
    task automatic wait_done(input string tag, input int lat0, input int exp_busy, output int lat);
        int busy_ok;
        busy_ok = 1;
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== exp_busy[0]) busy_ok = 0;
            step();
            lat++;
        end
        check({tag, "_busy_window"}, busy_ok, 1);
        check({tag, "_busy_in_done"}, int'(bus.busy), 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        issue(v.dd, v.dv);
        wait_done(tag, 1, (v.dz != 0) ? 0 : 1, lat);
        check({tag, "_latency"}, lat, (v.dz != 0) ? 1 : LAT);
        check({tag, "_quotient"}, q_act(), v.q);
        check({tag, "_remainder"}, r_act(), v.r);
        check({tag, "_div_zero"}, int'(bus.div_zero), v.dz);
        check({tag, "_ovf"}, int'(bus.ovf), v.ov);
        step();
        check({tag, "_done_pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        int lat;
        int saw_done;
        n_vec = 0;
        n_err = 0;

        //          dd    dv    q     r   dz ov
        vecs[0]  = '{  81,   9,    9,  0, 0, 0};
        vecs[1]  = '{ -81,   9,   -9,  0, 0, 0};
        vecs[2]  = '{  17,  -5,   -3,  2, 0, 0};
        vecs[3]  = '{ -17,   5,   -3, -2, 0, 0};
        vecs[4]  = '{ -17,  -5,    3, -2, 0, 0};
        vecs[5]  = '{   0,   7,    0,  0, 0, 0};
        vecs[6]  = '{   7,   0,    0,  0, 1, 0};
        vecs[7]  = '{   8,   2,    4,  0, 0, 0};
        vecs[8]  = '{-512,  -1, OVF_Q, 0, 0, 1};
        vecs[9]  = '{-512,   1, -512,  0, 0, 0};
        vecs[10] = '{ 511, -16,  -31, 15, 0, 0};
        vecs[11] = '{-512,  15,  -34, -2, 0, 0};

        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) step();
        check("reset_quotient", q_act(), 0);
        check("reset_remainder", r_act(), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_div_zero", int'(bus.div_zero), 0);
        check("reset_ovf", int'(bus.ovf), 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // start pulsed mid-division is ignored and operands are not re-sampled
        issue(81, 9);
        repeat (4) step();
        bus.start    = 1'b1;
        bus.dividend = N'(50);
        bus.divisor  = M'(5);
        step();
        bus.start = 1'b0;
        wait_done("ign", 6, 1, lat);
        check("ign_latency", lat, LAT);
        check("ign_quotient", q_act(), 9);
        check("ign_remainder", r_act(), 0);
        step();
        check("ign_done_pulse", int'(bus.done), 0);
        issue(50, 5);
        wait_done("fresh", 1, 1, lat);
        check("fresh_latency", lat, LAT);
        check("fresh_quotient", q_act(), 10);
        step();

        // reset mid-division aborts with no done pulse
        issue(81, 9);
        repeat (5) step();
        rst = 1'b0;
        step();
        check("abort_quotient", q_act(), 0);
        check("abort_remainder", r_act(), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_div_zero", int'(bus.div_zero), 0);
        check("abort_ovf", int'(bus.ovf), 0);
        rst = 1'b1;
        saw_done = 0;
        repeat (15) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        issue(9, 3);
        wait_done("post", 1, 1, lat);
        check("post_latency", lat, LAT);
        check("post_quotient", q_act(), 3);
        check("post_remainder", r_act(), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
